// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter
//   Shares one single-port frame-buffer memory between display refill
//   (keeps a small pixel FIFO ahead of the LCD timing generator) and
//   rasterizer draw writes. Owns front/back buffer selection; swaps only
//   at top-of-screen so scanout never tears.
//
// Ports
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   iTopOfScreen        one-cycle pulse per frame (vertical blanking)
//   iPixReq             display consumes one pixel this cycle
//   oPixData            FIFO head, first-word fall-through, 0 when empty
//   oUnderflow          sticky: pixel requested while FIFO empty
//   iWrValid/oWrReady   draw write handshake
//   iWrAddr, iWrData    draw write address (within back buffer) and pixel
//   iSwapReq            request a buffer swap at next top-of-screen
//   oSwapPending        swap requested, not yet applied
//   oFrontSel           buffer currently scanned out
//   oMemEn, oMemWe      registered memory command strobes
//   oMemAddr            registered address, MSB is buffer select
//   oMemWData           registered write data
//   iMemRData           read data, valid MEM_LAT cycles after command
module lcd_fb_arbiter #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LOW_WATER   = 8,
  parameter int unsigned FRAME_WORDS = 384000,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iTopOfScreen,
  input  logic              iPixReq,
  output logic [DATA_W-1:0] oPixData,
  output logic              oUnderflow,
  input  logic              iWrValid,
  output logic              oWrReady,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iSwapReq,
  output logic              oSwapPending,
  output logic              oFrontSel,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W:0]   oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + MEM_LAT + 2) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  // One bit per outstanding read; bit MEM_LAT marks data arriving this cycle.
  logic [MEM_LAT:0]  tag_pipe;
  logic [OCC_W-1:0]  in_flight, occ;
  logic              fetching, urgent, rd_issue, wr_issue;
  logic              push, pop, fifo_empty;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i <= MEM_LAT; i++)
      in_flight = in_flight + OCC_W'(tag_pipe[i]);
  end

  // Reads are held off in the flush cycle: their tag would be discarded and
  // fetch_addr is being rewound, so issuing one would only waste a slot.
  always_comb begin
    occ        = OCC_W'(count) + in_flight;
    fetching   = (state == S_FETCH);
    urgent     = fetching && (occ < OCC_W'(LOW_WATER));
    oWrReady   = !urgent;
    wr_issue   = iWrValid && !urgent;
    rd_issue   = fetching && !iTopOfScreen &&
                 (urgent || (!iWrValid && (occ < OCC_W'(FIFO_DEPTH))));
    fifo_empty = (count == '0);
    push       = tag_pipe[MEM_LAT] && !iTopOfScreen;
    pop        = iPixReq && !fifo_empty && !iTopOfScreen;
    oPixData   = fifo_empty ? '0 : fifo_mem[rd_ptr];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (iTopOfScreen) state_nx = S_FETCH;
      S_FETCH: begin
        if (iTopOfScreen)
          state_nx = S_FETCH;
        else if (rd_issue && (fetch_addr == LAST_ADDR))
          state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= S_IDLE;
      fetch_addr   <= '0;
      tag_pipe     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      oUnderflow   <= 1'b0;
      oFrontSel    <= 1'b0;
      oSwapPending <= 1'b0;
      oMemEn       <= 1'b0;
      oMemWe       <= 1'b0;
      oMemAddr     <= '0;
      oMemWData    <= '0;
    end else begin
      state <= state_nx;

      if (iTopOfScreen)
        fetch_addr <= '0;
      else if (rd_issue)
        fetch_addr <= fetch_addr + ADDR_W'(1);

      tag_pipe <= iTopOfScreen ? '0 : {tag_pipe[MEM_LAT-1:0], rd_issue};

      if (iTopOfScreen) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !push)
          count <= count - CNT_W'(1);
      end

      if (iPixReq && fifo_empty) oUnderflow <= 1'b1;

      if (iTopOfScreen && (oSwapPending || iSwapReq)) begin
        oFrontSel    <= ~oFrontSel;
        oSwapPending <= 1'b0;
      end else if (iSwapReq) begin
        oSwapPending <= 1'b1;
      end

      oMemEn <= rd_issue || wr_issue;
      oMemWe <= wr_issue;
      if (wr_issue) begin
        oMemAddr  <= {~oFrontSel, iWrAddr};
        oMemWData <= iWrData;
      end else if (rd_issue) begin
        oMemAddr <= {oFrontSel, fetch_addr};
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) fifo_mem[wr_ptr] <= iMemRData;
  end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// tb_lcd_fb_arbiter
//   Directed bench for lcd_fb_arbiter with a small configuration
//   (8-entry FIFO, low water 4, 32-pixel frame, read latency 2).
//   The memory model returns the requested address as read data.
module tb_lcd_fb_arbiter;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned MEM_LAT = 2;

  logic              iCLK = 1'b0;
  logic              iRST_N;
  logic              iTopOfScreen;
  logic              iPixReq;
  logic [DATA_W-1:0] oPixData;
  logic              oUnderflow;
  logic              iWrValid;
  logic              oWrReady;
  logic [ADDR_W-1:0] iWrAddr;
  logic [DATA_W-1:0] iWrData;
  logic              iSwapReq;
  logic              oSwapPending;
  logic              oFrontSel;
  logic              oMemEn;
  logic              oMemWe;
  logic [ADDR_W:0]   oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic [DATA_W-1:0] iMemRData;

  lcd_fb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (8),
    .LOW_WATER   (4),
    .FRAME_WORDS (32),
    .MEM_LAT     (MEM_LAT)
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iTopOfScreen (iTopOfScreen),
    .iPixReq      (iPixReq),
    .oPixData     (oPixData),
    .oUnderflow   (oUnderflow),
    .iWrValid     (iWrValid),
    .oWrReady     (oWrReady),
    .iWrAddr      (iWrAddr),
    .iWrData      (iWrData),
    .iSwapReq     (iSwapReq),
    .oSwapPending (oSwapPending),
    .oFrontSel    (oFrontSel),
    .oMemEn       (oMemEn),
    .oMemWe       (oMemWe),
    .oMemAddr     (oMemAddr),
    .oMemWData    (oMemWData),
    .iMemRData    (iMemRData)
  );

  always #5 iCLK = ~iCLK;

  // Memory model: data = address, MEM_LAT cycles after the command.
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];
  always @(posedge iCLK) begin
    rd_pipe[0] <= DATA_W'(oMemAddr);
    rd_pipe[1] <= rd_pipe[0];
  end
  assign iMemRData = rd_pipe[MEM_LAT-1];

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Command log, sampled mid-cycle.
  logic [ADDR_W:0]   rd_q [$];
  logic [ADDR_W:0]   wa_q [$];
  logic [DATA_W-1:0] wd_q [$];
  int                first_rd_cyc = -1;

  always @(negedge iCLK) begin
    if (oMemEn) begin
      if (oMemWe) begin
        wa_q.push_back(oMemAddr);
        wd_q.push_back(oMemWData);
      end else begin
        rd_q.push_back(oMemAddr);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_at(input int k);
    return (k < rd_q.size()) ? 32'(rd_q[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wa_at(input int k);
    return (k < wa_q.size()) ? 32'(wa_q[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wd_at(input int k);
    return (k < wd_q.size()) ? 32'(wd_q[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic clr_log();
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    first_rd_cyc = -1;
  endtask

  task automatic pulse_tos();
    iTopOfScreen = 1'b1;
    tick(1);
    iTopOfScreen = 1'b0;
  endtask

  int p;

  initial begin
    iRST_N = 1'b0; iTopOfScreen = 1'b0; iPixReq = 1'b0; iWrValid = 1'b0;
    iWrAddr = '0; iWrData = '0; iSwapReq = 1'b0;
    tick(2);

    // Reset state
    check("rst_memen",   32'(oMemEn),       0);
    check("rst_memwe",   32'(oMemWe),       0);
    check("rst_memaddr", 32'(oMemAddr),     0);
    check("rst_wdata",   32'(oMemWData),    0);
    check("rst_front",   32'(oFrontSel),    0);
    check("rst_pending", 32'(oSwapPending), 0);
    check("rst_uflow",   32'(oUnderflow),   0);
    check("rst_pix",     32'(oPixData),     0);
    check("rst_wrready", 32'(oWrReady),     1);
    iRST_N = 1'b1;
    clr_log();

    // Idle: no commands without a top-of-screen
    tick(50);
    check("idle_cmds", 32'(rd_q.size() + wa_q.size()), 0);
    check("idle_pix",  32'(oPixData), 0);

    // First frame fill: 8 reads, first command two cycles after the pulse
    clr_log();
    p = cyc;
    pulse_tos();
    tick(3);
    check("fill_pix_p4", 32'(oPixData), 0);
    tick(26);
    check("fill_rd_cnt",  32'(rd_q.size()), 8);
    check("fill_latency", 32'(first_rd_cyc - p), 2);
    for (int k = 0; k < 8; k++) check("fill_rd_addr", rd_at(k), 32'(k));

    // Drain the whole frame in order, then underflow
    for (int k = 0; k < 32; k++) begin
      iPixReq = 1'b1;
      check("pix_seq", 32'(oPixData), 32'(k));
      tick(1);
    end
    check("uflow_pre", 32'(oUnderflow), 0);
    check("empty_pix", 32'(oPixData), 0);
    tick(1);
    iPixReq = 1'b0;
    check("uflow_set", 32'(oUnderflow), 1);
    tick(10);
    check("frame_rd_cnt", 32'(rd_q.size()), 32);
    for (int k = 0; k < 32; k++) check("frame_rd_addr", rd_at(k), 32'(k));
    check("uflow_sticky", 32'(oUnderflow), 1);

    // Writes win until occupancy drops below low water
    clr_log();
    pulse_tos();
    tick(19);
    for (int k = 0; k < 6; k++) begin
      iWrValid = 1'b1;
      iWrAddr  = ADDR_W'(32'h100 + k);
      iWrData  = DATA_W'(32'hA00000 + k);
      iPixReq  = 1'b1;
      check("wr_ready", 32'(oWrReady), (k < 5) ? 1 : 0);
      tick(1);
    end
    iWrValid = 1'b0;
    iPixReq  = 1'b0;
    tick(2);
    check("wr_cnt", 32'(wa_q.size()), 5);
    for (int k = 0; k < 5; k++) begin
      check("wr_addr", wa_at(k), 32'h400100 + k);
      check("wr_data", wd_at(k), 32'hA00000 + k);
    end
    check("urgent_rd_addr", rd_at(8), 8);

    // Swap request mid-frame, applied at next top-of-screen
    iSwapReq = 1'b1;
    tick(1);
    iSwapReq = 1'b0;
    check("swap_pending", 32'(oSwapPending), 1);
    check("swap_front_hold", 32'(oFrontSel), 0);
    tick(5);
    check("swap_pending_hold", 32'(oSwapPending), 1);
    clr_log();
    pulse_tos();
    check("swap_front", 32'(oFrontSel), 1);
    check("swap_cleared", 32'(oSwapPending), 0);
    tick(20);
    check("swap_rd_cnt", 32'(rd_q.size()), 8);
    check("swap_rd_addr", rd_at(0), 32'h400000);
    check("swap_pix", 32'(oPixData), 32'h400000);
    iWrValid = 1'b1;
    iWrAddr  = ADDR_W'(32'h55);
    iWrData  = DATA_W'(32'h123456);
    check("swap_wr_ready", 32'(oWrReady), 1);
    tick(1);
    iWrValid = 1'b0;
    tick(2);
    check("swap_wr_cnt", 32'(wa_q.size()), 1);
    check("swap_wr_addr", wa_at(0), 32'h000055);
    check("swap_wr_data", wd_at(0), 32'h123456);

    // Top-of-screen with two reads in flight: stale data dropped
    iPixReq = 1'b1;
    tick(2);
    iPixReq = 1'b0;
    tick(1);
    pulse_tos();
    clr_log();
    tick(20);
    check("flush_rd_cnt", 32'(rd_q.size()), 8);
    check("flush_rd_addr", rd_at(0), 32'h400000);
    for (int k = 0; k < 8; k++) begin
      iPixReq = 1'b1;
      check("flush_pix", 32'(oPixData), 32'h400000 + k);
      tick(1);
    end
    iPixReq = 1'b0;

    // Asynchronous reset mid-operation
    tick(1);
    iRST_N = 1'b0;
    #1;
    check("arst_memen", 32'(oMemEn),     0);
    check("arst_addr",  32'(oMemAddr),   0);
    check("arst_front", 32'(oFrontSel),  0);
    check("arst_uflow", 32'(oUnderflow), 0);
    check("arst_pix",   32'(oPixData),   0);
    tick(2);
    iRST_N = 1'b1;
    clr_log();
    tick(20);
    check("arst_idle_rd", 32'(rd_q.size()), 0);
    check("arst_idle_pix", 32'(oPixData), 0);

    // Swap request coincident with top-of-screen
    iSwapReq     = 1'b1;
    iTopOfScreen = 1'b1;
    tick(1);
    iSwapReq     = 1'b0;
    iTopOfScreen = 1'b0;
    check("coinc_front", 32'(oFrontSel), 1);
    check("coinc_pending", 32'(oSwapPending), 0);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
